// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by the CPU, the character-map video reader and
// the keyboard mailbox writer. Accesses are pipelined: grant, RAM cycle, completion.
module mem_arbiter #(
  parameter logic [31:0] VID_BASE     = 32'h0000_2000,
  parameter logic [31:0] KBD_ADDR     = 32'h0000_3FFC,
  parameter int          STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  input  logic [7:0]  kbd_data,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_VID,
    GRANT_KBD,
    GRANT_CPU
  } grant_t;

  grant_t        grant;
  logic          cpu_busy;
  logic          vid_busy;
  logic          cpu_tag;
  logic          vid_tag;
  logic          kbd_pend;
  logic [7:0]    kbd_last;
  logic [7:0]    kbd_buf;
  logic [SW-1:0] starve_cnt;
  logic          cpu_elig;
  logic          vid_elig;
  logic          kbd_change;

  assign cpu_elig   = cpu_req & ~cpu_busy;
  assign vid_elig   = vid_req & ~vid_busy;
  assign kbd_change = (kbd_data != kbd_last);

  // A starved CPU overrides the normal video > keyboard > CPU order.
  always_comb begin
    grant = GRANT_NONE;
    if (cpu_elig && (starve_cnt == STARVE_MAX)) grant = GRANT_CPU;
    else if (vid_elig)                          grant = GRANT_VID;
    else if (kbd_pend)                          grant = GRANT_KBD;
    else if (cpu_elig)                          grant = GRANT_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (grant)
        GRANT_VID: begin
          ram_en   <= 1'b1;
          ram_addr <= VID_BASE + {18'd0, vid_addr};
        end
        GRANT_KBD: begin
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= KBD_ADDR;
          ram_wdata <= {24'h0, kbd_buf};
        end
        GRANT_CPU: begin
          ram_en    <= 1'b1;
          ram_we    <= cpu_we;
          ram_addr  <= cpu_addr;
          ram_wdata <= cpu_wdata;
        end
        default: ;
      endcase
    end
  end

  // Tags follow each access one stage behind the RAM port; busy spans grant to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_tag    <= 1'b0;
      vid_tag    <= 1'b0;
      cpu_ready  <= 1'b0;
      vid_valid  <= 1'b0;
      cpu_busy   <= 1'b0;
      vid_busy   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      cpu_tag   <= (grant == GRANT_CPU);
      vid_tag   <= (grant == GRANT_VID);
      cpu_ready <= cpu_tag;
      vid_valid <= vid_tag;
      if (grant == GRANT_CPU) cpu_busy <= 1'b1;
      else if (cpu_ready)     cpu_busy <= 1'b0;
      if (grant == GRANT_VID) vid_busy <= 1'b1;
      else if (vid_valid)     vid_busy <= 1'b0;
      if (grant == GRANT_CPU)
        starve_cnt <= '0;
      else if (cpu_elig && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A change arriving on the grant edge keeps the mailbox pending with the newer byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_last <= 8'h00;
      kbd_buf  <= 8'h00;
      kbd_pend <= 1'b0;
    end else begin
      kbd_last <= kbd_data;
      if (kbd_change) begin
        kbd_pend <= 1'b1;
        kbd_buf  <= kbd_data;
      end else if (grant == GRANT_KBD) begin
        kbd_pend <= 1'b0;
      end
    end
  end

  assign cpu_rdata = cpu_ready ? ram_rdata : 32'h0;
  assign vid_data  = vid_valid ? ram_rdata[15:0] : 16'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter with a behavioural RAM read model
// and a second instance whose video base sits near the top of the address space.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic [7:0]  kbd_data;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] w_cpu_rdata;
  logic        w_cpu_ready;
  logic [15:0] w_vid_data;
  logic        w_vid_valid;
  logic        w_ram_en;
  logic        w_ram_we;
  logic [31:0] w_ram_addr;
  logic [31:0] w_ram_wdata;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .kbd_data(kbd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.VID_BASE(32'hFFFF_FFF0)) dut_wrap (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(w_cpu_rdata), .cpu_ready(w_cpu_ready),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(w_vid_data), .vid_valid(w_vid_valid),
    .kbd_data(kbd_data),
    .ram_en(w_ram_en), .ram_we(w_ram_we), .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents are a fixed function of the address, with one special word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial ram_rdata = 32'h0;
  always @(posedge clk)
    if (ram_en && !ram_we) ram_rdata <= mem_word(ram_addr);

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic [7:0]  kbd;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        valid;
    logic [15:0] vdata;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic vr, input logic [13:0] va, input logic [7:0] kb,
    input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wd,
    input logic rdy, input logic [31:0] rd, input logic vv, input logic [15:0] vd);
    vec_t v;
    v.cpu_req = cr;  v.cpu_we = cw;  v.cpu_addr = ca;  v.cpu_wdata = cd;
    v.vid_req = vr;  v.vid_addr = va; v.kbd = kb;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wd;
    v.ready = rdy; v.rdata = rd; v.valid = vv; v.vdata = vd;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cpu_req   = v.cpu_req;
    cpu_we    = v.cpu_we;
    cpu_addr  = v.cpu_addr;
    cpu_wdata = v.cpu_wdata;
    vid_req   = v.vid_req;
    vid_addr  = v.vid_addr;
    kbd_data  = v.kbd;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " ram_en"},    {31'd0, ram_en},    32'h0);
    check_output({tag, " ram_we"},    {31'd0, ram_we},    32'h0);
    check_output({tag, " ram_addr"},  ram_addr,           32'h0);
    check_output({tag, " ram_wdata"}, ram_wdata,          32'h0);
    check_output({tag, " cpu_ready"}, {31'd0, cpu_ready}, 32'h0);
    check_output({tag, " cpu_rdata"}, cpu_rdata,          32'h0);
    check_output({tag, " vid_valid"}, {31'd0, vid_valid}, 32'h0);
    check_output({tag, " vid_data"},  {16'd0, vid_data},  32'h0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] st_addr [5];
    logic        st_we   [5];

    //               cpu: req we addr        wdata          vid: req addr     kbd   | en we addr         wdata          rdy rdata          vv vdata
    vecs[0]  = mk(1, 0, 32'h10,  32'h0,        0, 14'h0,    8'h00, 1, 0, 32'h10,   32'h0,        0, 32'h0,        0, 16'h0);
    vecs[1]  = mk(1, 0, 32'h10,  32'h0,        0, 14'h0,    8'h00, 0, 0, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0, 16'h0);
    vecs[2]  = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h00, 0, 0, 32'h10,   32'h0,        0, 32'h0,        0, 16'h0);
    vecs[3]  = mk(1, 0, 32'h40,  32'h0,        1, 14'h5,    8'h00, 1, 0, 32'h2005, 32'h0,        0, 32'h0,        0, 16'h0);
    vecs[4]  = mk(1, 0, 32'h40,  32'h0,        1, 14'h5,    8'h00, 1, 0, 32'h40,   32'h0,        0, 32'h0,        1, 16'hDFFA);
    vecs[5]  = mk(1, 0, 32'h40,  32'h0,        0, 14'h5,    8'h00, 0, 0, 32'h40,   32'h0,        1, 32'h0040FFBF, 0, 16'h0);
    vecs[6]  = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h00, 0, 0, 32'h40,   32'h0,        0, 32'h0,        0, 16'h0);
    vecs[7]  = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h1C, 0, 0, 32'h40,   32'h0,        0, 32'h0,        0, 16'h0);
    vecs[8]  = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h1C, 1, 1, 32'h3FFC, 32'h1C,       0, 32'h0,        0, 16'h0);
    vecs[9]  = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h1C, 0, 0, 32'h3FFC, 32'h1C,       0, 32'h0,        0, 16'h0);
    vecs[10] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h1C, 0, 0, 32'h3FFC, 32'h1C,       0, 32'h0,        0, 16'h0);
    vecs[11] = mk(1, 1, 32'h100, 32'hCAFEF00D, 0, 14'h0,    8'h1C, 1, 1, 32'h100,  32'hCAFEF00D, 0, 32'h0,        0, 16'h0);
    vecs[12] = mk(1, 1, 32'h100, 32'hCAFEF00D, 0, 14'h0,    8'h1C, 0, 0, 32'h100,  32'hCAFEF00D, 1, 32'h0,        0, 16'h0);
    vecs[13] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h1C, 0, 0, 32'h100,  32'hCAFEF00D, 0, 32'h0,        0, 16'h0);
    vecs[14] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h2A, 0, 0, 32'h100,  32'hCAFEF00D, 0, 32'h0,        0, 16'h0);
    vecs[15] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h3B, 1, 1, 32'h3FFC, 32'h2A,       0, 32'h0,        0, 16'h0);
    vecs[16] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h3B, 1, 1, 32'h3FFC, 32'h3B,       0, 32'h0,        0, 16'h0);
    vecs[17] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h3B, 0, 0, 32'h3FFC, 32'h3B,       0, 32'h0,        0, 16'h0);
    vecs[18] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h4C, 0, 0, 32'h3FFC, 32'h3B,       0, 32'h0,        0, 16'h0);
    vecs[19] = mk(0, 0, 32'h0,   32'h0,        1, 14'h3FFF, 8'h5D, 1, 0, 32'h5FFF, 32'h3B,       0, 32'h0,        0, 16'h0);
    vecs[20] = mk(0, 0, 32'h0,   32'h0,        1, 14'h3FFF, 8'h5D, 1, 1, 32'h3FFC, 32'h5D,       0, 32'h0,        1, 16'hA000);
    vecs[21] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h5D, 0, 0, 32'h3FFC, 32'h5D,       0, 32'h0,        0, 16'h0);
    vecs[22] = mk(0, 0, 32'h0,   32'h0,        0, 14'h0,    8'h5D, 0, 0, 32'h3FFC, 32'h5D,       0, 32'h0,        0, 16'h0);

    st_addr = '{32'h2001, 32'h3FFC, 32'h3FFC, 32'h80, 32'h2001};
    st_we   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check_output($sformatf("row%0d ram_en", i),    {31'd0, ram_en},    {31'd0, vecs[i].en});
      check_output($sformatf("row%0d ram_we", i),    {31'd0, ram_we},    {31'd0, vecs[i].we});
      check_output($sformatf("row%0d ram_addr", i),  ram_addr,           vecs[i].addr);
      check_output($sformatf("row%0d ram_wdata", i), ram_wdata,          vecs[i].wdata);
      check_output($sformatf("row%0d cpu_ready", i), {31'd0, cpu_ready}, {31'd0, vecs[i].ready});
      check_output($sformatf("row%0d vid_valid", i), {31'd0, vid_valid}, {31'd0, vecs[i].valid});
      if (vecs[i].ready && !vecs[i].cpu_we)
        check_output($sformatf("row%0d cpu_rdata", i), cpu_rdata, vecs[i].rdata);
      if (vecs[i].valid)
        check_output($sformatf("row%0d vid_data", i), {16'd0, vid_data}, {16'd0, vecs[i].vdata});
      if (i == 19)
        check_output("wrap ram_addr", w_ram_addr, 32'h0000_3FEF);
    end

    // Video held and the keyboard changing every cycle: the CPU must break through.
    for (int e = 0; e < 5; e++) begin
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h80;
      vid_req  = 1'b1;
      vid_addr = 14'h1;
      kbd_data = 8'h60 + 8'(e);
      tick();
      check_output($sformatf("starve e%0d ram_en", e + 1),   {31'd0, ram_en}, 32'h1);
      check_output($sformatf("starve e%0d ram_addr", e + 1), ram_addr, st_addr[e]);
      check_output($sformatf("starve e%0d ram_we", e + 1),   {31'd0, ram_we}, {31'd0, st_we[e]});
    end
    check_output("starve cpu_ready", {31'd0, cpu_ready}, 32'h1);
    check_output("starve cpu_rdata", cpu_rdata, 32'h0080_FF7F);

    cpu_req  = 1'b0;
    vid_req  = 1'b0;
    kbd_data = 8'h00;
    repeat (5) tick();

    // Reset lands in C1 of a CPU read; the requester re-requests afterwards.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h10;
    tick();
    check_output("pre-reset ram_en", {31'd0, ram_en}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    cpu_req = 1'b0;
    #1;
    reset = 1'b0;
    tick();
    check_output("postreset cpu_ready", {31'd0, cpu_ready}, 32'h0);
    check_output("postreset ram_en",    {31'd0, ram_en},    32'h0);
    cpu_req = 1'b1;
    tick();
    check_output("rereq ram_en",   {31'd0, ram_en}, 32'h1);
    check_output("rereq ram_addr", ram_addr,        32'h10);
    tick();
    check_output("rereq cpu_ready", {31'd0, cpu_ready}, 32'h1);
    check_output("rereq cpu_rdata", cpu_rdata,          32'hDEAD_BEEF);
    cpu_req = 1'b0;
    tick();
    check_output("rereq ready drop", {31'd0, cpu_ready}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter VID_BASE, default 32'h0000_2000: RAM address of character-map word 0.
REQ-002 SHALL have parameter KBD_ADDR, default 32'h0000_3FFC: RAM address of the keyboard mailbox word.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3: number of lost eligible cycles after which the CPU wins.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- vid_req  in  1  video read request; held until vid_valid.
- vid_addr  in  14  character index.
- vid_data  out  16  character word; valid when vid_valid=1.
- vid_valid  out  1  one-cycle completion pulse.
- kbd_data  in  8  current scan byte from the PS/2 receiver.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid the cycle after ram_en.

Function
REQ-005 SHALL issue at most one RAM access per cycle; ram_en/ram_we/ram_addr/ram_wdata SHALL be registered, asserted in cycle C1 following grant edge E0.
REQ-006 SHALL complete each read in C2: the completion pulse and data (= ram_rdata) SHALL be driven from a registered tag during C2; a CPU write SHALL also pulse cpu_ready in C2.
REQ-007 SHALL track busy flags cpu_busy and vid_busy: set at the grant edge, cleared at the edge ending C2; a busy requester SHALL be ineligible.
REQ-008 SHALL register kbd_data into kbd_last each cycle; kbd_data != kbd_last SHALL set kbd_pend and latch the byte in kbd_buf; a newer change before grant SHALL overwrite kbd_buf.
REQ-009 SHALL apply fixed priority among eligible requesters: video > keyboard (kbd_pend) > CPU, except REQ-010.
REQ-010 SHALL keep starve_cnt: increment on edges where the CPU is eligible and not granted, saturating at STARVE_LIMIT; at STARVE_LIMIT the CPU SHALL win over all; starve_cnt SHALL clear on CPU grant.
REQ-011 SHALL form the video access as ram_addr = VID_BASE + zero-extended vid_addr with ram_we=0, and return vid_data = ram_rdata[15:0].
REQ-012 SHALL form the keyboard access as ram_addr = KBD_ADDR, ram_we=1, ram_wdata = {24'h0, kbd_buf}; the grant SHALL clear kbd_pend unless a new change arrives on the same edge, in which case kbd_pend SHALL stay set with the new byte.
REQ-013 SHALL form the CPU access as ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata.
REQ-014 SHALL hold ram_en=0, ram_we=0 in any cycle with no grant; ram_addr/ram_wdata SHALL hold their last values.
REQ-015 SHALL use 32-bit modulo address addition, with wrap and no error on overflow.

Reset
REQ-016 SHALL on reset clear all outputs, busy flags, tags, kbd_pend, kbd_buf and starve_cnt to 0, and kbd_last to 8'h00.
REQ-017 SHALL drop any in-flight access on mid-operation reset, with no completion pulse afterward; the requester re-requests.

Verification
REQ-018 CPU read, idle bus: cpu_req=1, cpu_we=0, cpu_addr=32'h10 at E0 -> ram_en=1, ram_addr=32'h10 in C1; ram_rdata=32'hDEADBEEF -> cpu_ready=1, cpu_rdata=32'hDEADBEEF in C2 only.
REQ-019 Simultaneous requests: vid_req (vid_addr=14'h5) and cpu_req at the same edge -> ram_addr=32'h2005 first, CPU granted the next edge.
REQ-020 Starvation: vid_req held continuously plus cpu_req -> CPU granted no later than the 4th eligible edge, then video resumes.
REQ-021 Keyboard: kbd_data 8'h00 -> 8'h1C, idle -> one write ram_addr=32'h3FFC, ram_wdata=32'h1C; kbd_data steady -> no further writes.
REQ-022 Reset in C1 of a CPU read -> all outputs 0, no cpu_ready pulse, next cpu_req served normally.
